collision_detector: RTL

- Producer of the goodColl/badColl event pulses consumed by the score tracker/display path.
- On each snake move, checks the new head position against walls, apple and every stored body segment, then emits exactly one classified result.
- Body segments are read from the snake body RAM through a synchronous read port.
- Sits between the movement FSM (which issues move_strobe) and the score tracker.

---
 rtl/collision_detector.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/collision_detector.sv
// collision_detector
// Classifies each snake move as apple eaten (goodColl), wall/self hit (badColl)
// or nothing, and emits exactly one result per accepted move_strobe.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   move_strobe_i           one-cycle request; head/apple/len inputs valid
//   head_x_i, head_y_i      new head position
//   apple_x_i, apple_y_i    apple position
//   snake_len_i             body segment count (clamped to MAX_LEN)
//   body_addr_o             body RAM read address (synchronous RAM)
//   body_x_i, body_y_i      segment position, valid one cycle after address
//   goodColl_o, badColl_o   one-cycle result pulses, never both high
//   done_o                  one-cycle pulse, check finished
//   busy_o                  high from the accepting edge until done
//   dropped_o               one-cycle pulse, strobe arrived while not ready
//
// State | meaning
// IDLE   | waiting for move_strobe
// SCAN   | walking body RAM, comparing each returned segment with the head
// REPORT | wall / empty-body result known, pulses go out at the next edge
module collision_detector #(
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 12,
    parameter int MAX_LEN = 50,
    parameter int AW      = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          move_strobe_i,
    input  logic [3:0]    head_x_i,
    input  logic [3:0]    head_y_i,
    input  logic [3:0]    apple_x_i,
    input  logic [3:0]    apple_y_i,
    input  logic [6:0]    snake_len_i,
    output logic [AW-1:0] body_addr_o,
    input  logic [3:0]    body_x_i,
    input  logic [3:0]    body_y_i,
    output logic          goodColl_o,
    output logic          badColl_o,
    output logic          done_o,
    output logic          busy_o,
    output logic          dropped_o
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    localparam logic [6:0] MAX_LEN_V = 7'(MAX_LEN);
    localparam logic [4:0] GRID_W_V  = 5'(GRID_W);
    localparam logic [4:0] GRID_H_V  = 5'(GRID_H);

    state_t        state_q;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] last_idx_q;
    logic [3:0]    head_x_q;
    logic [3:0]    head_y_q;
    logic          apple_hit_q;
    logic          cmp_valid_q;
    logic          cmp_last_q;
    logic          res_good_q;
    logic          res_bad_q;
    logic          good_q;
    logic          bad_q;
    logic          done_q;
    logic          busy_q;
    logic          dropped_q;

    logic [6:0]    len_c;
    logic          wall_c;
    logic          apple_c;
    logic          body_hit_c;

    assign len_c      = (snake_len_i > MAX_LEN_V) ? MAX_LEN_V : snake_len_i;
    // Widen by one bit so a 16-wide grid still compares correctly.
    assign wall_c     = ({1'b0, head_x_i} >= GRID_W_V) || ({1'b0, head_y_i} >= GRID_H_V);
    assign apple_c    = (head_x_i == apple_x_i) && (head_y_i == apple_y_i);
    assign body_hit_c = (body_x_i == head_x_q) && (body_y_i == head_y_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            last_idx_q  <= '0;
            head_x_q    <= '0;
            head_y_q    <= '0;
            apple_hit_q <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_last_q  <= 1'b0;
            res_good_q  <= 1'b0;
            res_bad_q   <= 1'b0;
            good_q      <= 1'b0;
            bad_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            good_q    <= 1'b0;
            bad_q     <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;

            // The cycle carrying done is not ready for a new request either.
            if (move_strobe_i && ((state_q != IDLE) || done_q)) begin
                dropped_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (move_strobe_i && !done_q) begin
                        busy_q      <= 1'b1;
                        head_x_q    <= head_x_i;
                        head_y_q    <= head_y_i;
                        apple_hit_q <= apple_c;
                        cmp_valid_q <= 1'b0;
                        cmp_last_q  <= 1'b0;
                        if (wall_c) begin
                            res_good_q <= 1'b0;
                            res_bad_q  <= 1'b1;
                            state_q    <= REPORT;
                        end else if (len_c == 7'd0) begin
                            res_good_q <= apple_c;
                            res_bad_q  <= 1'b0;
                            state_q    <= REPORT;
                        end else begin
                            idx_q      <= '0;
                            last_idx_q <= AW'(len_c - 7'd1);
                            state_q    <= SCAN;
                        end
                    end
                end

                SCAN: begin
                    // Data on body_x/y belongs to the address issued one
                    // cycle earlier; cmp_valid/cmp_last track that segment.
                    if (cmp_valid_q && body_hit_c) begin
                        bad_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cmp_valid_q && cmp_last_q) begin
                        good_q  <= apple_hit_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cmp_valid_q <= 1'b1;
                        cmp_last_q  <= (idx_q == last_idx_q);
                        if (idx_q != last_idx_q) begin
                            idx_q <= idx_q + AW'(1);
                        end
                    end
                end

                REPORT: begin
                    good_q  <= res_good_q;
                    bad_q   <= res_bad_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // idx only moves in SCAN, so the address naturally holds elsewhere.
    assign body_addr_o = idx_q;
    assign goodColl_o  = good_q;
    assign badColl_o   = bad_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign dropped_o   = dropped_q;

endmodule
